// File: rtl/mem_access_stage.sv
// EX/MEM pipeline register and load/store unit: captures EX results, runs a req/ack
// data-memory access, formats store/load data and stalls upstream while busy.
module mem_access_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_length,
  input  logic        ex_sign,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_write_reg,
  input  logic        ex_reg_write,
  input  logic        ex_mem_to_reg,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        mem_stall,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic [4:0]  wb_write_reg,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_load_data,
  output logic        misalign_exc,
  output logic        bus_err
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_nxt;

  logic [31:0]   r_addr, r_data;
  logic [1:0]    r_len;
  logic          r_sign, r_read, r_write, r_rw, r_m2r;
  logic [4:0]    r_rd;
  logic [CW-1:0] cnt;

  logic       ex_mem_op, ex_misalign, cnt_expired;
  logic [1:0] off;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;
  logic [3:0]  st_be;

  assign ex_mem_op   = ex_mem_read | ex_mem_write;
  assign ex_misalign = (ex_length == 2'd1 && ex_alu_result[0]) ||
                       (ex_length[1] && (|ex_alu_result[1:0]));
  assign cnt_expired = (cnt == CW'(TIMEOUT - 1));

  // FSM: state register
  always_ff @(negedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ex_mem_op && !ex_misalign) state_nxt = ACCESS;
      ACCESS:  if (dm_ack || cnt_expired)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs (async reset drops the request immediately)
  always_comb begin
    dm_req    = (state == ACCESS);
    mem_stall = (state == ACCESS);
  end

  // Store formatting from the captured operation
  assign off = r_addr[1:0];
  always_comb begin
    st_be    = 4'b1111;
    dm_wdata = r_data;
    case (r_len)
      2'd0: begin
        st_be    = 4'b0001 << off;
        dm_wdata = {4{r_data[7:0]}};
      end
      2'd1: begin
        st_be    = off[1] ? 4'b1100 : 4'b0011;
        dm_wdata = {2{r_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign dm_we   = r_write;
  assign dm_addr = {r_addr[31:2], 2'b00};
  assign dm_be   = r_write ? st_be : 4'b0000;

  // Load lane select and extension
  assign ld_byte = dm_rdata[{off, 3'b000} +: 8];
  assign ld_half = off[1] ? dm_rdata[31:16] : dm_rdata[15:0];
  always_comb begin
    case (r_len)
      2'd0:    ld_fmt = {{24{r_sign & ld_byte[7]}}, ld_byte};
      2'd1:    ld_fmt = {{16{r_sign & ld_half[15]}}, ld_half};
      default: ld_fmt = dm_rdata;
    endcase
  end

  assign wb_alu_result = r_addr;
  assign wb_write_reg  = r_rd;
  assign wb_mem_to_reg = r_m2r;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= '0;
      r_data       <= '0;
      r_len        <= '0;
      r_sign       <= 1'b0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_rw         <= 1'b0;
      r_m2r        <= 1'b0;
      r_rd         <= '0;
      cnt          <= '0;
      wb_reg_write <= 1'b0;
      wb_load_data <= '0;
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
      if (state == IDLE) begin
        r_addr  <= ex_alu_result;
        r_data  <= ex_store_data;
        r_len   <= ex_length;
        r_sign  <= ex_sign;
        r_read  <= ex_mem_read;
        r_write <= ex_mem_write;
        r_rw    <= ex_reg_write;
        r_m2r   <= ex_mem_to_reg;
        r_rd    <= ex_write_reg;
        cnt     <= '0;
        // memory ops retire later (or never, if misaligned): bubble now
        if (!ex_mem_op) begin
          wb_reg_write <= ex_reg_write && (|ex_write_reg);
        end else begin
          wb_reg_write <= 1'b0;
          misalign_exc <= ex_misalign;
        end
      end else begin
        wb_reg_write <= 1'b0;
        if (dm_ack) begin
          wb_load_data <= ld_fmt;
          // read+write is a store: never retires a load value
          wb_reg_write <= r_rw && (|r_rd) && !(r_read && r_write);
        end else if (cnt_expired) begin
          bus_err <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed literal checks plus randomized traffic compared
// every cycle against a transaction-level model.
module tb_mem_access_stage;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_mem_read = 1'b0, ex_mem_write = 1'b0, ex_sign = 1'b0;
  logic [1:0]  ex_length = '0;
  logic [31:0] ex_alu_result = '0, ex_store_data = '0;
  logic [4:0]  ex_write_reg = '0;
  logic        ex_reg_write = 1'b0, ex_mem_to_reg = 1'b0;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = '0;
  logic        dm_req, dm_we, mem_stall, wb_reg_write, wb_mem_to_reg, misalign_exc, bus_err;
  logic [31:0] dm_addr, dm_wdata, wb_alu_result, wb_load_data;
  logic [3:0]  dm_be;
  logic [4:0]  wb_write_reg;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_length(ex_length),
    .ex_sign(ex_sign), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_write_reg(ex_write_reg), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .mem_stall(mem_stall),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_write_reg(wb_write_reg),
    .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data),
    .misalign_exc(misalign_exc), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int acc_size(logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_misaligned(logic [1:0] len, logic [31:0] a);
    return (a % acc_size(len)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(logic [1:0] len, logic [31:0] a);
    int sz = acc_size(len);
    int start = (a % 4) - ((a % 4) % sz);
    return 4'(((1 << sz) - 1) << start);
  endfunction

  function automatic logic [31:0] exp_wdata(logic [1:0] len, logic [31:0] d);
    if (len == 2'd0) return {24'd0, d[7:0]} * 32'h0101_0101;
    if (len == 2'd1) return {16'd0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(logic [31:0] w, logic [31:0] a, logic [1:0] len, bit sgn);
    int sz = acc_size(len);
    int start = (a % 4) - ((a % 4) % sz);
    int bits = 8 * sz;
    logic [31:0] mask, v;
    mask = (bits == 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
    v = (w >> (8 * start)) & mask;
    if (sgn && bits < 32 && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  bit          m_busy = 0, m_read = 0, m_write = 0, m_sign = 0, m_rw = 0, m_m2r = 0;
  bit          m_wbrw = 0, m_mis = 0, m_berr = 0;
  bit [31:0]   m_addr = 0, m_data = 0, m_ld = 0;
  bit [1:0]    m_len = 0;
  bit [4:0]    m_rd = 0;
  int          m_wait = 0;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_read <= 0; m_write <= 0; m_sign <= 0; m_rw <= 0; m_m2r <= 0;
      m_wbrw <= 0; m_mis <= 0; m_berr <= 0; m_addr <= 0; m_data <= 0; m_ld <= 0;
      m_len <= 0; m_rd <= 0; m_wait <= 0;
    end else begin
      m_mis  <= 0;
      m_berr <= 0;
      if (!m_busy) begin
        m_addr <= ex_alu_result; m_data <= ex_store_data; m_len <= ex_length;
        m_sign <= ex_sign; m_read <= ex_mem_read; m_write <= ex_mem_write;
        m_rw <= ex_reg_write; m_m2r <= ex_mem_to_reg; m_rd <= ex_write_reg;
        if (!(ex_mem_read || ex_mem_write)) m_wbrw <= ex_reg_write && ex_write_reg != 0;
        else begin
          m_wbrw <= 0;
          if (is_misaligned(ex_length, ex_alu_result)) m_mis <= 1;
          else begin m_busy <= 1; m_wait <= 0; end
        end
      end else begin
        m_wbrw <= 0;
        if (dm_ack) begin
          m_ld   <= exp_load(dm_rdata, m_addr, m_len, m_sign);
          m_wbrw <= m_rw && m_rd != 0 && !(m_read && m_write);
          m_busy <= 0;
        end else if (m_wait + 1 == TIMEOUT) begin
          m_berr <= 1;
          m_busy <= 0;
        end else m_wait <= m_wait + 1;
      end
    end
  end

  task automatic cmp(string n, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h, expected %h", n, $time, act, exp);
    end
  endtask

  // Compare every cycle on the non-active edge
  always @(posedge clk) begin
    if (chk_en) begin
      vectors++;
      cmp("dm_req", 32'(dm_req), 32'(m_busy));
      cmp("mem_stall", 32'(mem_stall), 32'(m_busy));
      cmp("wb_reg_write", 32'(wb_reg_write), 32'(m_wbrw));
      cmp("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(m_m2r));
      cmp("wb_write_reg", 32'(wb_write_reg), 32'(m_rd));
      cmp("wb_alu_result", wb_alu_result, m_addr);
      cmp("wb_load_data", wb_load_data, m_ld);
      cmp("misalign_exc", 32'(misalign_exc), 32'(m_mis));
      cmp("bus_err", 32'(bus_err), 32'(m_berr));
      if (m_busy) begin
        cmp("dm_we", 32'(dm_we), 32'(m_write));
        cmp("dm_addr", dm_addr, m_addr & 32'hFFFF_FFFC);
        cmp("dm_be", 32'(dm_be), m_write ? 32'(exp_be(m_len, m_addr)) : 32'd0);
        cmp("dm_wdata", dm_wdata, exp_wdata(m_len, m_data));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    vectors++;
    cmp(n, act, exp);
  endtask

  task automatic drive(bit rd_op, bit wr_op, logic [1:0] len, bit sgn, logic [31:0] a,
                       logic [31:0] d, logic [4:0] wr, bit rw, bit m2r);
    ex_mem_read = rd_op; ex_mem_write = wr_op; ex_length = len; ex_sign = sgn;
    ex_alu_result = a; ex_store_data = d; ex_write_reg = wr; ex_reg_write = rw;
    ex_mem_to_reg = m2r;
  endtask

  task automatic nop();
    drive(0, 0, 2'd0, 0, 32'd0, 32'd0, 5'd0, 0, 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    tick(); tick();
    chk("reset dm_req", 32'(dm_req), 0);
    chk("reset mem_stall", 32'(mem_stall), 0);
    chk("reset wb_reg_write", 32'(wb_reg_write), 0);
    chk("reset wb_alu_result", wb_alu_result, 0);
    chk("reset wb_load_data", wb_load_data, 0);
    chk("reset bus_err", 32'(bus_err | misalign_exc), 0);
    rst = 1'b0;

    // non-memory pass-through
    drive(0, 0, 2'd2, 0, 32'h1234, 32'd0, 5'd5, 1, 0);
    tick();
    chk("alu pass wb_alu_result", wb_alu_result, 32'h1234);
    chk("alu pass wb_reg_write", 32'(wb_reg_write), 1);
    chk("alu pass wb_write_reg", 32'(wb_write_reg), 5);
    chk("alu pass mem_stall", 32'(mem_stall), 0);

    // LB signed, byte 3
    drive(1, 0, 2'd0, 1, 32'h103, 32'd0, 5'd7, 1, 1);
    tick();
    chk("lb mem_stall", 32'(mem_stall), 1);
    chk("lb dm_addr", dm_addr, 32'h100);
    chk("lb dm_be", 32'(dm_be), 0);
    nop(); dm_ack = 1'b1; dm_rdata = 32'h80FF_0000;
    tick();
    dm_ack = 1'b0;
    chk("lb stall released", 32'(mem_stall), 0);
    chk("lb wb_load_data", wb_load_data, 32'hFFFF_FF80);
    chk("lb wb_reg_write", 32'(wb_reg_write), 1);

    // LHU upper half
    drive(1, 0, 2'd1, 0, 32'h102, 32'd0, 5'd8, 1, 1);
    tick();
    chk("lhu dm_addr", dm_addr, 32'h100);
    nop(); dm_ack = 1'b1; dm_rdata = 32'hBEEF_1234;
    tick();
    dm_ack = 1'b0;
    chk("lhu wb_load_data", wb_load_data, 32'h0000_BEEF);

    // SB byte 1
    drive(0, 1, 2'd0, 0, 32'h201, 32'h1234_56AB, 5'd0, 0, 0);
    tick();
    chk("sb dm_we", 32'(dm_we), 1);
    chk("sb dm_be", 32'(dm_be), 32'b0010);
    chk("sb dm_wdata", dm_wdata, 32'hABAB_ABAB);
    nop(); dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    chk("sb done", 32'(mem_stall | wb_reg_write), 0);

    // misaligned LW
    drive(1, 0, 2'd2, 0, 32'h102, 32'd0, 5'd9, 1, 1);
    tick();
    chk("lw mis dm_req", 32'(dm_req), 0);
    chk("lw mis misalign_exc", 32'(misalign_exc), 1);
    chk("lw mis wb_reg_write", 32'(wb_reg_write), 0);
    nop();
    tick();
    chk("lw mis pulse width", 32'(misalign_exc), 0);

    // timeout
    drive(1, 0, 2'd2, 0, 32'h200, 32'd0, 5'd10, 1, 1);
    tick();
    nop();
    repeat (TIMEOUT - 1) tick();
    chk("timeout still stalled", 32'(mem_stall), 1);
    tick();
    chk("timeout bus_err", 32'(bus_err), 1);
    chk("timeout stall released", 32'(mem_stall), 0);
    chk("timeout wb_reg_write", 32'(wb_reg_write), 0);
    tick();
    chk("timeout pulse width", 32'(bus_err), 0);

    // reset mid-access
    drive(0, 1, 2'd2, 0, 32'h300, 32'hDEAD_BEEF, 5'd0, 0, 0);
    tick();
    chk("rst mid dm_req before", 32'(dm_req), 1);
    rst = 1'b1;
    #1;
    chk("rst mid dm_req", 32'(dm_req), 0);
    chk("rst mid mem_stall", 32'(mem_stall), 0);
    tick();
    rst = 1'b0;
    nop();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] a;
      int op;
      a = $urandom();
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      op = $urandom_range(0, 9);
      drive(op == 4 || op == 5 || op == 8 || op == 9, op == 6 || op == 7 || op == 8,
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom(),
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom()),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      dm_rdata = $urandom();
      if (dm_req) dm_ack = ($urandom_range(0, 9) < 4);
      else        dm_ack = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        #1 rst = 1'b0;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
